dbg_halt_ctrl: RTL and testbench

Sequences entry into and exit from debug mode for the rv32imf core. It accepts halt and resume requests from the debug module, ebreak commits and single-step retires. It stalls fetch, issues the pipeline flush, and waits for the core to report empty. It then drives debug_on, flush_flag and the dpc/dcsr update strobes into the core's linearization and CSR logic.

---
 rtl/dbg_pkg.sv | 17 +
 rtl/dbg_drain_timer.sv | 29 ++
 rtl/dbg_halt_ctrl.sv | 113 +++++++++++
 tb/tb_dbg_halt_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and cause codes for the debug halt/resume sequencer.
package dbg_pkg;

   // Adjacent transitions along the main loop differ in one bit.
   typedef enum logic [2:0] {
      RUN      = 3'b000,
      DRAIN    = 3'b001,
      HALTED   = 3'b011,
      RESUMING = 3'b010,
      STEP     = 3'b100
   } dbg_state_e;

   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/dbg_drain_timer.sv
// Saturating drain-cycle counter: increments while enabled, clears when idle.
module dbg_drain_timer #(
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr,
   input  logic                                 en,
   output logic [$clog2(DRAIN_TIMEOUT+1)-1:0]   cnt,
   output logic                                 done
);

   localparam int CNT_W = $clog2(DRAIN_TIMEOUT+1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DRAIN_TIMEOUT);

   // Enable wins over clear so the entry edge already counts the first cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt != LIMIT) cnt <= cnt + CNT_W'(1);
      end else if (clr) begin
         cnt <= '0;
      end
   end

   assign done = (cnt == LIMIT);

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug-mode entry/exit sequencer: stalls fetch, flushes, drains, halts, resumes.
module dbg_halt_ctrl
   import dbg_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       haltreq,
   input  logic       resumereq,
   input  logic       step_en,
   input  logic       ebreak_commit,
   input  logic       instr_retire,
   input  logic       empty_core,
   output logic       debug_on,
   output logic       fetch_halt,
   output logic       flush_flag,
   output logic       halted,
   output logic       resumeack,
   output logic       dpc_we,
   output logic [2:0] dcsr_cause,
   output logic       drain_err
);

   localparam int CNT_W = $clog2(DRAIN_TIMEOUT+1);

   dbg_state_e       state_q, state_d;
   logic [2:0]       cause_d;
   logic [CNT_W-1:0] drain_cnt;
   logic             drain_done;
   logic             enter_drain;
   logic             empty_seen;
   logic             exit_hit;

   dbg_drain_timer #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != DRAIN),
      .en   (state_d == DRAIN),
      .cnt  (drain_cnt),
      .done (drain_done)
   );

   // empty_core is ignored in the first DRAIN cycle, while the flush is still in flight.
   assign empty_seen  = empty_core && (drain_cnt > CNT_W'(1));
   assign exit_hit    = (state_q == DRAIN) && !dpc_we && (empty_seen || drain_done);
   assign enter_drain = (state_d == DRAIN) && (state_q != DRAIN);

   always_comb begin
      state_d = state_q;
      cause_d = dcsr_cause;
      case (state_q)
         RUN: begin
            if (ebreak_commit) begin
               state_d = DRAIN;
               cause_d = CAUSE_EBREAK;
            end else if (haltreq) begin
               state_d = DRAIN;
               cause_d = CAUSE_HALTREQ;
            end
         end
         // dpc_we marks the final DRAIN cycle; the halt takes effect on the next edge.
         DRAIN: begin
            if (dpc_we) state_d = HALTED;
         end
         HALTED: begin
            if (resumereq && !haltreq) state_d = RESUMING;
         end
         RESUMING: begin
            state_d = step_en ? STEP : RUN;
         end
         STEP: begin
            if (ebreak_commit) begin
               state_d = DRAIN;
               cause_d = CAUSE_EBREAK;
            end else if (haltreq) begin
               state_d = DRAIN;
               cause_d = CAUSE_HALTREQ;
            end else if (instr_retire) begin
               state_d = DRAIN;
               cause_d = CAUSE_STEP;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         flush_flag <= 1'b0;
         dpc_we     <= 1'b0;
         resumeack  <= 1'b0;
         dcsr_cause <= '0;
         drain_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_flag <= enter_drain;
         dpc_we     <= exit_hit;
         resumeack  <= (state_d == RESUMING) && (state_q != RESUMING);
         dcsr_cause <= cause_d;
         if (exit_hit && !empty_seen) drain_err <= 1'b1;
         else if (state_q == RESUMING) drain_err <= 1'b0;
      end
   end

   assign debug_on   = (state_q == HALTED);
   assign halted     = (state_q == HALTED);
   assign fetch_halt = (state_q == DRAIN) || (state_q == HALTED);

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Directed bench for dbg_halt_ctrl: per-cycle vector table plus reset and wait sequences.
module tb_dbg_halt_ctrl;

   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       haltreq = 1'b0, resumereq = 1'b0, step_en = 1'b0;
   logic       ebreak_commit = 1'b0, instr_retire = 1'b0, empty_core = 1'b0;
   logic       debug_on, fetch_halt, flush_flag, halted, resumeack, dpc_we, drain_err;
   logic [2:0] dcsr_cause;

   dbg_halt_ctrl #(.DRAIN_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .haltreq       (haltreq),
      .resumereq     (resumereq),
      .step_en       (step_en),
      .ebreak_commit (ebreak_commit),
      .instr_retire  (instr_retire),
      .empty_core    (empty_core),
      .debug_on      (debug_on),
      .fetch_halt    (fetch_halt),
      .flush_flag    (flush_flag),
      .halted        (halted),
      .resumeack     (resumeack),
      .dpc_we        (dpc_we),
      .dcsr_cause    (dcsr_cause),
      .drain_err     (drain_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] in;   // {haltreq, resumereq, step_en, ebreak, retire, empty}
      logic [9:0] exp;  // {debug_on, fetch_halt, flush, halted, resumeack, dpc_we, cause[2:0], drain_err}
   } vec_t;

   vec_t vecs[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic logic [5:0] I(int h, int r, int s, int eb, int ret, int emp);
      return {1'(h), 1'(r), 1'(s), 1'(eb), 1'(ret), 1'(emp)};
   endfunction

   function automatic logic [9:0] E(int dbg, int fh, int fl, int h, int ra, int dw, int c, int err);
      return {1'(dbg), 1'(fh), 1'(fl), 1'(h), 1'(ra), 1'(dw), 3'(c), 1'(err)};
   endfunction

   function automatic logic [9:0] outs();
      return {debug_on, fetch_halt, flush_flag, halted, resumeack, dpc_we, dcsr_cause, drain_err};
   endfunction

   task automatic add(input logic [5:0] in, input logic [9:0] exp);
      vec_t v;
      v.in  = in;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic add_n(input int n, input logic [5:0] in, input logic [9:0] exp);
      for (int k = 0; k < n; k++) add(in, exp);
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input logic [5:0] in);
      {haltreq, resumereq, step_en, ebreak_commit, instr_retire, empty_core} = in;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      // haltreq from RUN, empty_core rising in cycle 5, then plain resume
      add  (I(1,0,0,0,0,0), E(0,1,1,0,0,0,3,0));
      add_n(4, I(1,0,0,0,0,0), E(0,1,0,0,0,0,3,0));
      add  (I(1,0,0,0,0,1), E(0,1,0,0,0,1,3,0));
      add  (I(1,0,0,0,0,1), E(1,1,0,1,0,0,3,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,3,0));
      add  (I(0,1,0,0,0,0), E(0,0,0,0,1,0,3,0));
      add  (I(0,0,0,0,0,0), E(0,0,0,0,0,0,3,0));
      // ebreak + haltreq together; empty ignored in the first DRAIN cycle; resume under haltreq dropped
      add  (I(1,0,0,1,0,0), E(0,1,1,0,0,0,1,0));
      add  (I(1,0,0,0,0,1), E(0,1,0,0,0,0,1,0));
      add  (I(1,0,0,0,0,1), E(0,1,0,0,0,1,1,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,1,0));
      add  (I(1,1,0,0,0,0), E(1,1,0,1,0,0,1,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,1,0));
      // single step: resume with step_en, retire three cycles after resumeack
      add  (I(0,1,1,0,0,0), E(0,0,0,0,1,0,1,0));
      add_n(3, I(0,0,1,0,0,0), E(0,0,0,0,0,0,1,0));
      add  (I(0,0,0,0,1,0), E(0,1,1,0,0,0,4,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,0,4,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,1,4,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,4,0));
      // drain timeout with empty_core held low; drain_err clears once RESUMING completes
      add  (I(0,1,0,0,0,0), E(0,0,0,0,1,0,4,0));
      add  (I(0,0,0,0,0,0), E(0,0,0,0,0,0,4,0));
      add  (I(1,0,0,0,0,0), E(0,1,1,0,0,0,3,0));
      add_n(TMO-1, I(1,0,0,0,0,0), E(0,1,0,0,0,0,3,0));
      add  (I(1,0,0,0,0,0), E(0,1,0,0,0,1,3,1));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,3,1));
      add  (I(0,1,0,0,0,0), E(0,0,0,0,1,0,3,1));
      add  (I(0,0,0,0,0,0), E(0,0,0,0,0,0,3,0));
      // ebreak entry, then STEP with haltreq and retire together: haltreq beats step
      add  (I(0,0,0,1,0,0), E(0,1,1,0,0,0,1,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,0,1,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,1,1,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,1,0));
      add  (I(0,1,1,0,0,0), E(0,0,0,0,1,0,1,0));
      add  (I(0,0,1,0,0,0), E(0,0,0,0,0,0,1,0));
      add  (I(1,0,1,0,1,0), E(0,1,1,0,0,0,3,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,0,3,0));
      add  (I(0,0,0,0,0,1), E(0,1,0,0,0,1,3,0));
      add  (I(0,0,0,0,0,0), E(1,1,0,1,0,0,3,0));

      #12;
      check("reset_state", outs(), E(0,0,0,0,0,0,0,0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].in);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // asynchronous reset while HALTED
      rst = 1'b0;
      #1;
      check("rst_in_halted", outs(), E(0,0,0,0,0,0,0,0));
      @(negedge clk);
      rst = 1'b1;
      apply(I(0,0,0,0,0,0));
      check("run_after_rst_halted", outs(), E(0,0,0,0,0,0,0,0));

      // asynchronous reset in the first DRAIN cycle, flush pulse live
      apply(I(1,0,0,0,0,0));
      check("drain_before_rst", outs(), E(0,1,1,0,0,0,3,0));
      haltreq = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_in_drain", outs(), E(0,0,0,0,0,0,0,0));
      @(negedge clk);
      rst = 1'b1;
      apply(I(0,0,0,0,0,0));
      check("run_after_rst_drain", outs(), E(0,0,0,0,0,0,0,0));

      // bounded wait for halted with empty_core already high
      {haltreq, empty_core} = 2'b11;
      cyc = 0;
      while (!halted && cyc < 20) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      check("halt_wait_reached", 10'(halted), 10'(1));
      check("halt_wait_cycles", 10'(cyc), 10'(4));
      check("halt_wait_outs", outs(), E(1,1,0,1,0,0,3,0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
